dma_controller: RTL
===================

# dma_controller

Boot-time and run-time receive DMA engine sitting between the UART receiver and the memory controller hub. It assembles received bytes into 32-bit words. During boot it streams a length-prefixed program into the code segment via `instr_ready`/`data`, then acknowledges the host over UART TX. After boot it forwards every received datum to the hub's input ring buffer via `mem_ready`/`data`.

## Interface
Parameters:
- `ACK_BYTE`, default 8'hAA: byte transmitted once the program load completes.
- `MAX_INSTR`, default 256: code-segment capacity in words; words beyond this are received but not written.

Ports:
- `clock`  in  1  system clock.
- `reset`  in  1  reset; one clock, asynchronous, active-high.
- `rx_ready`  in  1  one-cycle pulse: `rdata` holds a new received byte.
- `rdata`  in  8  received byte.
- `tx_busy`  in  1  UART TX busy.
- `instr_ready`  out  1  one-cycle pulse: `data` is the next instruction word.
- `mem_ready`  out  1  one-cycle pulse: `data` is the next input-data word.
- `data`  out  32  assembled word.
- `tx_start`  out  1  one-cycle TX start pulse (ack only).
- `sdata`  out  8  TX byte.
- `program_loaded`  out  1  high from ack issue until reset.
- `led`  out  8  debug: {state[1:0], byte_cnt[1:0], instr_cnt[3:0]}.

## Operation
- **States:** `S_SIZE` → `S_LOAD` → `S_ACK` → `S_RUN`. `S_RUN` is terminal until reset.
- **Byte order:** all words are little-endian. The byte counter `byte_cnt` (2 bit) shifts bytes into `shreg[31:0]` at positions 0, 8, 16, 24. On `byte_cnt==3` with `rx_ready`, a word completes: `{rdata, shreg[23:0]}`. The counter then wraps to 0.
- **`S_SIZE`:**
  - The first completed word is the instruction count `N` (32-bit, unsigned); latch it into `remaining`.
  - If `N==0`, go to `S_ACK`; otherwise go to `S_LOAD`.
- **`S_LOAD`:**
  - Each completed word decrements `remaining`.
  - If fewer than `MAX_INSTR` words have been written, drive `data` and pulse `instr_ready`. Otherwise drop the word (no pulse).
  - When `remaining` reaches 0, go to `S_ACK`.
- **`S_ACK`:**
  - Wait until `tx_busy==0`, then pulse `tx_start` with `sdata=ACK_BYTE`, set `program_loaded`, and go to `S_RUN`.
  - Bytes received in `S_ACK` are discarded, and `byte_cnt` stays 0.
- **`S_RUN`:** see Configuration. Each produced word drives `data` and pulses `mem_ready`.
- **Mutual exclusion:** `instr_ready` and `mem_ready` are never high in the same cycle.
- **Instruction counter:** `instr_cnt` (32-bit) saturates at `MAX_INSTR`.

## Timing
- **Reset values:** all outputs 0 (`data`=0, `sdata`=0, `program_loaded`=0, `led`=0); state `S_SIZE`; counters 0.
- **Word output latency:** `instr_ready`/`mem_ready` rise one cycle after the `rx_ready` that completes a word, and last exactly one cycle. `data` changes in that same cycle and holds until the next word.
- **State update:** the state changes on the same edge as the word-completion output.
- **Ack latency:** `tx_start` rises in the first cycle of `S_ACK` for which `tx_busy` was sampled low, and is high for exactly one cycle. `program_loaded` rises on the same edge.
- **Back-to-back bytes:** `rx_ready` on consecutive cycles is legal, and every byte is accepted with no stall.
- **Asynchronous reset mid-word or mid-load:** the partial word and count are discarded, and the next byte is treated as byte 0 of `N`.

## Configuration
- **`DMA_WORD_PACK_EN` defined:** `S_RUN` packs 4 bytes per word, little-endian, exactly like `S_LOAD`; `mem_ready` fires once per 4 bytes.
- **`DMA_WORD_PACK_EN` undefined:** in `S_RUN`, each byte produces `data={24'b0, rdata}` and a `mem_ready` pulse one cycle after its `rx_ready`; `byte_cnt` is unused in `S_RUN`.
- Boot behaviour is identical in both builds.

## Structure
- **Package `dma_pkg`:**
  - typedef `dma_state_t` enum {`S_SIZE`, `S_LOAD`, `S_ACK`, `S_RUN`};
  - localparam `DMA_ACK_DEFAULT` = 8'hAA.
- **Sub-module `byte_packer`:**
  - Inputs: `clock`, `reset`, `clear`, `valid`, `byte_in`.
  - Outputs: `word_valid` pulse, `word[31:0]`.
  - Owns `shreg` and `byte_cnt`.
  - `clear` forces `byte_cnt` to 0 (used in `S_ACK`).
- **Top level:** the FSM, counters and TX pulse logic live in `dma_controller`.

## Test plan
- **Normal load:**
  - Stimulus: bytes 02 00 00 00, 78 56 34 12, EF BE AD DE.
  - Response: `instr_ready` pulses twice with `data`=0x12345678, then 0xDEADBEEF; then `tx_start` with `sdata`=0xAA; `program_loaded`=1.
- **Zero-length load:**
  - Stimulus: `N`=0 (00 00 00 00).
  - Response: no `instr_ready`; ack issued; state `S_RUN`.
- **Ack waits on TX:**
  - Stimulus: `tx_busy`=1 for 10 cycles entering `S_ACK`.
  - Response: `tx_start` asserts on the cycle after `tx_busy` falls; exactly one pulse.
- **Overflow clamp:**
  - Stimulus: `MAX_INSTR`=2, `N`=3.
  - Response: 2 `instr_ready` pulses; the third word is absorbed; ack follows the third word.
- **Run phase, both builds:**
  - Stimulus: after boot, send 41 42 43 44.
  - Response with `DMA_WORD_PACK_EN`: one `mem_ready`, `data`=0x44434241.
  - Response without: four `mem_ready` pulses, `data`=0x41, 0x42, 0x43, 0x44.
- **Reset mid-load:**
  - Stimulus: assert `reset` after 6 bytes of the load.
  - Response: outputs 0 immediately; the next 4 bytes are parsed as a fresh `N`.

Source files
------------

// File: rtl/dma_controller_pkg.sv
// dma_pkg: shared state encoding and defaults for the receive DMA engine.
// Contents: dma_state_t boot/run state enum, DMA_ACK_DEFAULT ack byte.
package dma_pkg;
    typedef enum logic [1:0] {S_SIZE, S_LOAD, S_ACK, S_RUN} dma_state_t;
    localparam logic [7:0] DMA_ACK_DEFAULT = 8'hAA;
endpackage

// File: rtl/dma_controller_byte_packer.sv
// byte_packer: assembles received bytes into little-endian 32-bit words.
// Ports: clock, reset (async, active-high), clear (hold byte count at 0),
//        valid/byte_in (received byte), word_valid (combinational pulse on the
//        completing byte), word (assembled word, valid with word_valid),
//        byte_cnt (current byte position, for debug).
module byte_packer (
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        valid,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word,
    output logic [1:0]  byte_cnt
);
    // Only the low three bytes are stored; the fourth arrives with the completion.
    logic [23:0] shreg;
    assign word_valid = valid && !clear && byte_cnt == 2'd3;
    assign word = {byte_in, shreg};
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            byte_cnt <= '0;
            shreg    <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
        end else if (valid) begin
            byte_cnt <= byte_cnt + 2'd1;
            shreg    <= byte_cnt == 2'd0 ? {shreg[23:8], byte_in} :
                        byte_cnt == 2'd1 ? {shreg[23:16], byte_in, shreg[7:0]} :
                        byte_cnt == 2'd2 ? {byte_in, shreg[15:0]} : shreg;
        end
endmodule

// File: rtl/dma_controller.sv
// dma_controller: boot-time program loader and run-time receive DMA from UART to memory hub.
// Ports: clock, reset (async, active-high), rx_ready/rdata (UART RX byte),
//        tx_busy (UART TX busy), instr_ready/data (code-segment word),
//        mem_ready/data (run-time input word), tx_start/sdata (ack byte),
//        program_loaded (set at ack), led (debug {state, byte_cnt, instr_cnt[3:0]}).
// Build option: DMA_WORD_PACK_EN packs run-time bytes into words; otherwise each
//               run-time byte is forwarded zero-extended.
module dma_controller
    import dma_pkg::*;
#(
    parameter logic [7:0] ACK_BYTE  = DMA_ACK_DEFAULT,
    parameter int         MAX_INSTR = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_ready,
    input  logic [7:0]  rdata,
    input  logic        tx_busy,
    output logic        instr_ready,
    output logic        mem_ready,
    output logic [31:0] data,
    output logic        tx_start,
    output logic [7:0]  sdata,
    output logic        program_loaded,
    output logic [7:0]  led
);
    dma_state_t  state, state_n;
    logic [31:0] remaining, instr_cnt, word, wdata;
    logic [1:0]  byte_cnt;
    logic        word_valid, clear, instr_we, mem_we, ack;

`ifdef DMA_WORD_PACK_EN
    assign clear = state == S_ACK;
`else
    // Byte-wise forwarding in S_RUN leaves the packer idle.
    assign clear = state == S_ACK || state == S_RUN;
`endif

    byte_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .valid      (rx_ready),
        .byte_in    (rdata),
        .word_valid (word_valid),
        .word       (word),
        .byte_cnt   (byte_cnt)
    );

    assign led = {state, byte_cnt, instr_cnt[3:0]};

    always_ff @(posedge clock or posedge reset)
        if (reset) state <= S_SIZE;
        else state <= state_n;

    always_comb begin
        state_n  = state;
        instr_we = 1'b0;
        mem_we   = 1'b0;
        ack      = 1'b0;
        wdata    = word;
        case (state)
            S_SIZE: if (word_valid) state_n = word == '0 ? S_ACK : S_LOAD;
            S_LOAD: if (word_valid) begin
                instr_we = instr_cnt < 32'(MAX_INSTR);
                state_n  = remaining == 32'd1 ? S_ACK : S_LOAD;
            end
            S_ACK: if (!tx_busy) begin
                ack     = 1'b1;
                state_n = S_RUN;
            end
            S_RUN: begin
`ifdef DMA_WORD_PACK_EN
                mem_we = word_valid;
`else
                mem_we = rx_ready;
                wdata  = {24'b0, rdata};
`endif
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            remaining      <= '0;
            instr_cnt      <= '0;
            data           <= '0;
            instr_ready    <= 1'b0;
            mem_ready      <= 1'b0;
            tx_start       <= 1'b0;
            sdata          <= '0;
            program_loaded <= 1'b0;
        end else begin
            instr_ready <= instr_we;
            mem_ready   <= mem_we;
            tx_start    <= ack;
            if (word_valid && state == S_SIZE) remaining <= word;
            if (word_valid && state == S_LOAD) remaining <= remaining - 32'd1;
            if (instr_we) instr_cnt <= instr_cnt + 32'd1;
            if (instr_we || mem_we) data <= wdata;
            if (ack) begin
                sdata          <= ACK_BYTE;
                program_loaded <= 1'b1;
            end
        end
endmodule
